// File: rtl/door_sequencer.sv
// Door cycle sequencer: warns, opens, holds and closes the door once per car arrival.
// Every phase is timed in prescaled ticks; the timer restarts on each phase entry.
module door_sequencer #(
  parameter int TICK_DIV    = 50000000,
  parameter int WARN_TICKS  = 3,
  parameter int OPEN_TICKS  = 5,
  parameter int CLOSE_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arrive,
  input  logic       open_btn,
  input  logic       close_btn,
  input  logic       obstruct,
  output logic       blink_start,
  output logic       door_open,
  output logic       moving,
  output logic       done,
  output logic [1:0] state
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [PW-1:0] PRESC_ZERO = PW'(0);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WARN    = 2'd1,
    OPEN    = 2'd2,
    CLOSING = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic [PW-1:0] presc_r;
  logic [PW-1:0] presc_nx_s;
  logic [3:0]    cnt_r;
  logic [3:0]    cnt_nx_s;
  logic [3:0]    cnt_inc_s;
  logic [3:0]    limit_s;
  logic          tick_s;
  logic          phase_end_s;
  logic          restart_s;
  logic          blink_nx_s;
  logic          door_open_nx_s;
  logic          moving_nx_s;
  logic          done_nx_s;

  // Next-state, timer and output decode
  always_comb begin
    state_nx_s     = state_r;
    restart_s      = 1'b0;
    presc_nx_s     = presc_r;
    cnt_nx_s       = cnt_r;
    limit_s        = 4'd0;
    tick_s         = (presc_r == PRESC_LAST);
    cnt_inc_s      = cnt_r + 4'd1;
    phase_end_s    = 1'b0;
    blink_nx_s     = 1'b0;
    door_open_nx_s = 1'b0;
    moving_nx_s    = 1'b0;
    done_nx_s      = 1'b0;

    case (state_r)
      WARN:    limit_s = 4'(WARN_TICKS);
      OPEN:    limit_s = 4'(OPEN_TICKS);
      CLOSING: limit_s = 4'(CLOSE_TICKS);
      default: limit_s = 4'd0;
    endcase
    phase_end_s = tick_s && (cnt_inc_s == limit_s);

    case (state_r)
      IDLE: begin
        restart_s = 1'b1;
        if (arrive) state_nx_s = WARN;
        else        state_nx_s = IDLE;
      end
      WARN: begin
        if (phase_end_s) state_nx_s = OPEN;
        else             state_nx_s = WARN;
      end
      OPEN: begin
        // A held open request or obstruction pins the timer at zero and beats close_btn
        if (open_btn || obstruct) restart_s  = 1'b1;
        else if (close_btn)       state_nx_s = CLOSING;
        else if (phase_end_s)     state_nx_s = CLOSING;
        else                      state_nx_s = OPEN;
      end
      CLOSING: begin
        if (obstruct || open_btn) state_nx_s = OPEN;
        else if (phase_end_s)     state_nx_s = IDLE;
        else                      state_nx_s = CLOSING;
      end
      default: state_nx_s = IDLE;
    endcase

    if ((state_nx_s != state_r) || restart_s) begin
      presc_nx_s = PRESC_ZERO;
      cnt_nx_s   = 4'd0;
    end else if (tick_s) begin
      presc_nx_s = PRESC_ZERO;
      cnt_nx_s   = cnt_inc_s;
    end else begin
      presc_nx_s = presc_r + PRESC_ONE;
      cnt_nx_s   = cnt_r;
    end

    blink_nx_s     = (state_r == IDLE) && (state_nx_s == WARN);
    done_nx_s      = (state_r == CLOSING) && (state_nx_s == IDLE);
    door_open_nx_s = (state_nx_s == OPEN);
    moving_nx_s    = (state_nx_s == WARN) || (state_nx_s == CLOSING);
  end

  // State, timer and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      presc_r     <= PRESC_ZERO;
      cnt_r       <= 4'd0;
      blink_start <= 1'b0;
      door_open   <= 1'b0;
      moving      <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      presc_r     <= presc_nx_s;
      cnt_r       <= cnt_nx_s;
      blink_start <= blink_nx_s;
      door_open   <= door_open_nx_s;
      moving      <= moving_nx_s;
      done        <= done_nx_s;
    end
  end

  assign state = state_r;

endmodule

// File: tb/tb_door_sequencer.sv
// Directed bench for door_sequencer with TICK_DIV=4, WARN=3, OPEN=2, CLOSE=1 ticks.
module tb_door_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       arrive;
  logic       open_btn;
  logic       close_btn;
  logic       obstruct;
  logic       blink_start;
  logic       door_open;
  logic       moving;
  logic       done;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  door_sequencer #(
    .TICK_DIV   (4),
    .WARN_TICKS (3),
    .OPEN_TICKS (2),
    .CLOSE_TICKS(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arrive     (arrive),
    .open_btn   (open_btn),
    .close_btn  (close_btn),
    .obstruct   (obstruct),
    .blink_start(blink_start),
    .door_open  (door_open),
    .moving     (moving),
    .done       (done),
    .state      (state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

  task automatic chk(input string tag, input int c, input logic [5:0] got, input logic [5:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed={st,bs,open,mov,done}=%b expected=%b", tag, c, got, exp);
  endtask

  // Advance into cycle c and compare all outputs against the expected state and pulses
  task automatic step_chk(input string tag, input int c, input logic [1:0] st, input logic bs, input logic dn);
    logic dop;
    logic mv;
    @(posedge clk);
    #1;
    dop = (st == 2'd2);
    mv  = (st == 2'd1) || (st == 2'd3);
    chk(tag, c, {state, blink_start, door_open, moving, done}, {st, bs, dop, mv, dn});
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    arrive    = 1'b1;
    open_btn  = 1'b1;
    close_btn = 1'b0;
    obstruct  = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("reset", 0, {state, blink_start, door_open, moving, done}, 6'b000000);
    reset    = 1'b0;
    arrive   = 1'b0;
    open_btn = 1'b0;
    obstruct = 1'b0;
  endtask

  // mode 0: nominal; 1: noise on ignored inputs during WARN; 2: arrive held high throughout
  task automatic run_nominal(input string tag, input int mode);
    logic [1:0] st;
    logic       bs;
    arrive = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      st = (c <= 12) ? 2'd1 : (c <= 20) ? 2'd2 : (c <= 24) ? 2'd3 : 2'd0;
      bs = (c == 1);
      if (mode == 2 && c == 26) begin
        st = 2'd1;
        bs = 1'b1;
      end else begin
        st = st;
        bs = bs;
      end
      step_chk(tag, c, st, bs, c == 25);
      if (mode == 2)                            arrive = 1'b1;
      else if (mode == 1 && c >= 2 && c <= 11)  arrive = c[0];
      else                                      arrive = 1'b0;
      open_btn = (mode == 1) && (c >= 3) && (c <= 10) && (c % 3 == 0);
      obstruct = (mode == 1) && (c >= 2) && (c <= 11) && c[1];
    end
    arrive   = 1'b0;
    open_btn = 1'b0;
    obstruct = 1'b0;
  endtask

  initial begin
    logic [1:0] st;
    reset     = 1'b1;
    arrive    = 1'b0;
    open_btn  = 1'b0;
    close_btn = 1'b0;
    obstruct  = 1'b0;

    do_reset();
    run_nominal("nominal", 0);

    do_reset();
    run_nominal("ignored", 1);

    do_reset();
    run_nominal("rearrive", 2);

    // close_btn in cycles 14-15 cuts OPEN short
    do_reset();
    arrive = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      st = (c <= 12) ? 2'd1 : (c <= 14) ? 2'd2 : (c <= 18) ? 2'd3 : 2'd0;
      step_chk("close_btn", c, st, c == 1, c == 19);
      arrive    = 1'b0;
      close_btn = (c == 14) || (c == 15);
    end
    close_btn = 1'b0;

    // obstruct pulse while closing reopens for a full OPEN phase
    do_reset();
    arrive = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      st = (c <= 12) ? 2'd1 : (c <= 20) ? 2'd2 : (c <= 22) ? 2'd3 :
           (c <= 30) ? 2'd2 : (c <= 34) ? 2'd3 : 2'd0;
      step_chk("obstruct_close", c, st, c == 1, c == 35);
      arrive   = 1'b0;
      obstruct = (c == 22);
    end
    obstruct = 1'b0;

    // open_btn and close_btn together hold OPEN; closes 8 cycles after release
    do_reset();
    arrive = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      st = (c <= 12) ? 2'd1 : (c <= 30) ? 2'd2 : (c <= 34) ? 2'd3 : 2'd0;
      step_chk("open_close_hold", c, st, c == 1, c == 35);
      arrive    = 1'b0;
      open_btn  = (c >= 13) && (c <= 22);
      close_btn = (c >= 13) && (c <= 22);
    end
    open_btn  = 1'b0;
    close_btn = 1'b0;

    // obstruct overrides close_btn in OPEN
    do_reset();
    arrive = 1'b1;
    for (int c = 1; c <= 31; c++) begin
      st = (c <= 12) ? 2'd1 : (c <= 25) ? 2'd2 : (c <= 29) ? 2'd3 : 2'd0;
      step_chk("obstruct_blocks_close", c, st, c == 1, c == 30);
      arrive    = 1'b0;
      obstruct  = (c >= 14) && (c <= 17);
      close_btn = (c >= 14) && (c <= 17);
    end
    obstruct  = 1'b0;
    close_btn = 1'b0;

    // reset during OPEN drops the cycle; a fresh arrival repeats nominal timing
    do_reset();
    arrive = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      st = (c <= 12) ? 2'd1 : 2'd2;
      step_chk("pre_reset", c, st, c == 1, 1'b0);
      arrive = 1'b0;
      reset  = (c == 16);
    end
    for (int c = 17; c <= 20; c++) begin
      step_chk("mid_reset", c, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
    end
    run_nominal("after_reset", 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/door_sequencer.md
# door_sequencer

Upstream stage of the door-warning blinker: sequences one full door cycle per car arrival (warn, open, close) and reports door status to the car controller. On arrival it issues a one-cycle `blink_start` to the blinker stage, waits out the warning period, holds the door open, then closes it. Open/close buttons and an obstruction sensor modify the cycle. All phase timing comes from a shared prescaled tick.

## Interface
- `TICK_DIV`, 50000000, clk cycles per tick (1 s at 50 MHz); legal range ≥ 2
- `WARN_TICKS`, 3, ticks spent in WARN (matches blinker's 3 blinks); 1..15
- `OPEN_TICKS`, 5, ticks door is held open; 1..15
- `CLOSE_TICKS`, 2, ticks spent closing; 1..15
- `clk` in 1 system clock, rising edge
- `reset` in 1 synchronous, active-high reset
- `arrive` in 1 level/pulse from car controller: car stopped at floor
- `open_btn` in 1 door-open request (synchronised level)
- `close_btn` in 1 door-close request (synchronised level)
- `obstruct` in 1 obstruction sensor, high = blocked
- `blink_start` out 1 one-cycle pulse to the blinker stage
- `door_open` out 1 high while door fully open
- `moving` out 1 high while door is moving (WARN or CLOSING)
- `done` out 1 one-cycle pulse: cycle complete, car may depart
- `state` out 2 IDLE=0, WARN=1, OPEN=2, CLOSING=3

## Operation
- Reset (sampled at edge): state IDLE, prescaler 0, tick count 0; all outputs 0.
- Prescaler: counts 0..TICK_DIV-1, `tick` internal when prescaler == TICK_DIV-1, wraps to 0. Prescaler and tick count both clear on every state entry and on every timer restart, so a phase of N ticks lasts exactly N*TICK_DIV cycles.
- Tick count: 4 bits; phase ends on the tick that makes count == phase limit.
- IDLE: `arrive`=1 -> WARN. All other inputs ignored.
- WARN: `blink_start`=1 for the first cycle only. After WARN_TICKS -> OPEN. Buttons and `obstruct` ignored.
- OPEN: `door_open`=1. After OPEN_TICKS -> CLOSING.
  - `open_btn` or `obstruct` high: timer restarts (held at 0 while high).
  - `close_btn` with `open_btn`=0 and `obstruct`=0 -> CLOSING next cycle.
  - `open_btn` and `close_btn` together: open wins.
- CLOSING: `moving`=1. After CLOSE_TICKS -> IDLE with `done`=1 in the first IDLE cycle.
  - `obstruct` or `open_btn` high -> OPEN next cycle, timer restarted; no `done`, no new `blink_start`.
- `arrive` outside IDLE ignored; a level still high when IDLE is re-entered starts a new cycle. `done` and the new WARN entry therefore occur in consecutive cycles.
- Outputs are registered and decoded from state and entry flags: `moving` = (state==WARN or CLOSING), `door_open` = (state==OPEN).

## Timing
- `arrive` sampled at edge k -> state=WARN and `blink_start`=1 during cycle k+1.
- WARN occupies cycles k+1 .. k+WARN_TICKS*TICK_DIV.
- `door_open` rises at k+WARN_TICKS*TICK_DIV+1.
- Input response in OPEN/CLOSING: one cycle (state changes at the next edge).
- `reset` mid-cycle: next cycle is IDLE with all outputs 0. No `done` is produced, and any `blink_start` in flight is dropped.
- Reset has priority over all inputs in the same cycle.

## Test plan
Bench parameters: TICK_DIV=4, WARN_TICKS=3, OPEN_TICKS=2, CLOSE_TICKS=1.
- Nominal: reset, then `arrive` pulse at edge 0 -> `blink_start` in cycle 1 only; WARN cycles 1–12; `door_open` cycles 13–20; `moving` cycles 21–24; `done` in cycle 25; state 0 afterward.
- Close button: `close_btn` held cycles 14–15 -> CLOSING from cycle 15; `done` in cycle 19.
- Obstruct on close: `obstruct` pulsed in cycle 22 -> OPEN in cycle 23 for a full 8 cycles, CLOSING 31–34, `done` in 35; no second `blink_start`.
- Priority/hold: `open_btn`+`close_btn` held in OPEN for 10 cycles -> stays OPEN; closes 8 cycles after release; `obstruct` in OPEN blocks `close_btn`.
- Ignored inputs: `arrive`, `open_btn`, and `obstruct` toggled during WARN -> timing identical to the nominal case.
- Reset mid-OPEN at cycle 16 -> cycle 17 has state 0 and all outputs 0; no `done`; a fresh `arrive` repeats the nominal timing.
